// File: rtl/adder_bist_checker.sv
// Exhaustive self-test engine for an adder: walks every {a,b} pair, lets the adder
// settle, compares {carry,sum} with a+b and keeps error count / first failing vector.
module adder_bist_checker #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned ERR_W      = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  input  logic [WIDTH-1:0]   sum_i,
  input  logic               carry_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [ERR_W-1:0]   err_cnt_o,
  output logic               first_fail_valid_o,
  output logic [2*WIDTH-1:0] first_fail_vec_o
);

  localparam int unsigned VW = 2 * WIDTH;
  localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;

  state_e          state_q;
  logic [VW-1:0]   vec_q;
  logic [CW-1:0]   settle_q;
  logic            busy_q, done_q, pass_q, ffv_q;
  logic [ERR_W-1:0] err_q;
  logic [VW-1:0]   ffvec_q;

  logic [WIDTH:0]  exp_d;
  logic            mismatch_d;

  // Operands come straight off the vector register, so they only move when vec_q does.
  assign a_o = vec_q[VW-1:WIDTH];
  assign b_o = vec_q[WIDTH-1:0];

  always_comb begin
    exp_d      = {1'b0, a_o} + {1'b0, b_o};
    mismatch_d = ({carry_i, sum_i} != exp_d);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q  <= SETTLE;
            vec_q    <= '0;
            settle_q <= SETTLE_INIT;
            err_q    <= '0;
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_q == '0) state_q <= CHECK;
          else                settle_q <= settle_q - CW'(1);
        end
        CHECK: begin
          if (mismatch_d) begin
            if (~&err_q) err_q <= err_q + ERR_W'(1);
            if (!ffv_q) begin
              ffv_q   <= 1'b1;
              ffvec_q <= vec_q;
            end
          end
          // Last vector ends the run instead of wrapping back to zero.
          if (&vec_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= !(ffv_q || mismatch_d);
          end else begin
            vec_q    <= vec_q + VW'(1);
            settle_q <= SETTLE_INIT;
            state_q  <= SETTLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign pass_o             = pass_q;
  assign err_cnt_o          = err_q;
  assign first_fail_valid_o = ffv_q;
  assign first_fail_vec_o   = ffvec_q;

endmodule
